// File: rtl/i8080_bus_master.sv
// i8080_bus_master: write-only 8080-style bus initiator.
// Accepts command/data bytes on a valid/ready stream and turns each one into a
// timed CS/RS/We/Data write cycle: SETUP -> STROBE -> HOLD -> GAP -> IDLE.
// With BURST set, a request accepted on the last HOLD cycle re-enters SETUP
// with CS still low, so the GAP and IDLE cycles are skipped.
module i8080_bus_master #(
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_PULSE = 1,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_GAP   = 2,
  parameter bit          BURST   = 1'b0
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       TxValid,
  input  logic       TxIsCmd,
  input  logic [7:0] TxData,
  output logic       TxReady,
  output logic       TxDone,
  output logic       Busy,
  output logic       J80_CS,
  output logic       J80_RS,
  output logic       J80_We,
  output logic [7:0] J80_Data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  // The counter is loaded with N-1 on state entry; a phase ends on the cycle it reads 0.
  localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cs_q, cs_d;
  logic       rs_q, rs_d;
  logic       we_q, we_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       last;
  logic       accept;

  assign last    = (cnt_q == 8'd0);
  assign TxReady = (state_q == S_IDLE) || (BURST && (state_q == S_HOLD) && last);
  assign Busy    = (state_q != S_IDLE);
  assign accept  = TxValid && TxReady;

  assign J80_CS   = cs_q;
  assign J80_RS   = rs_q;
  assign J80_We   = we_q;
  assign J80_Data = data_q;
  assign TxDone   = done_q;

  // Next-state logic: phase sequencing, bus pin updates and the TxDone pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? 8'd0 : cnt_q - 8'd1;
    cs_d    = cs_q;
    rs_d    = rs_q;
    we_d    = we_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Request is captured here only; later input changes are ignored.
          cs_d    = 1'b0;
          rs_d    = ~TxIsCmd;
          data_d  = TxData;
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (last) begin
          we_d    = 1'b1;
          state_d = S_STROBE;
          cnt_d   = LD_PULSE;
        end
      end
      S_STROBE: begin
        if (last) begin
          we_d    = 1'b0;
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
          // Single-cycle HOLD: its only cycle is also the final one.
          done_d  = (LD_HOLD == 8'd0);
        end
      end
      S_HOLD: begin
        if (!last) begin
          done_d = (cnt_q == 8'd1);
        end else if (accept) begin
          // Burst re-accept: We is already low, so RS/Data may change under CS=0.
          rs_d    = ~TxIsCmd;
          data_d  = TxData;
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end else begin
          cs_d    = 1'b1;
          state_d = S_GAP;
          cnt_d   = LD_GAP;
        end
      end
      S_GAP: begin
        if (last) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        cs_d    = 1'b1;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs; reset aborts any cycle in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      cs_q    <= 1'b1;
      rs_q    <= 1'b1;
      we_q    <= 1'b0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      rs_q    <= rs_d;
      we_q    <= we_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_i8080_bus_master.sv
// Bench for i8080_bus_master: three instances (default non-burst, default burst,
// stretched timing) driven with random command/data traffic. Each accepted byte
// is queued as the byte a bus receiver should latch; a monitor acts as that
// receiver (latching on We falling) and measures every phase width against the
// configured cycle counts.
module tb_i8080_bus_master;

  localparam int N = 3;

  function automatic int ts(input int i); return (i == 2) ? 3 : 1; endfunction
  function automatic int tp(input int i); return (i == 2) ? 4 : 1; endfunction
  function automatic int th(input int i); return (i == 2) ? 2 : 1; endfunction
  function automatic int tg(input int i); return (i == 2) ? 5 : 2; endfunction
  function automatic bit bu(input int i); return (i == 1); endfunction
  function automatic int per(input int i);
    return bu(i) ? ts(i) + tp(i) + th(i) : ts(i) + tp(i) + th(i) + tg(i) + 1;
  endfunction

  logic       CLK;
  logic       nRST;
  logic       tx_valid [N];
  logic       tx_iscmd [N];
  logic [7:0] tx_data  [N];
  logic       tx_ready [N];
  logic       tx_done  [N];
  logic       busy     [N];
  logic       j_cs     [N];
  logic       j_rs     [N];
  logic       j_we     [N];
  logic [7:0] j_data   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    i8080_bus_master #(
      .T_SETUP(ts(g)), .T_PULSE(tp(g)), .T_HOLD(th(g)), .T_GAP(tg(g)), .BURST(bu(g))
    ) u_dut (
      .CLK(CLK), .nRST(nRST),
      .TxValid(tx_valid[g]), .TxIsCmd(tx_iscmd[g]), .TxData(tx_data[g]),
      .TxReady(tx_ready[g]), .TxDone(tx_done[g]), .Busy(busy[g]),
      .J80_CS(j_cs[g]), .J80_RS(j_rs[g]), .J80_We(j_we[g]), .J80_Data(j_data[g])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] exp_q [N][$];

  // monitor state, per instance
  int cyc = 0;
  int lo_len [N];
  int hi_len [N];
  int we_len [N];
  int npulse [N];
  int ndone  [N];
  int fall_at[N];
  int last_acc[N];
  bit prev_cs[N];
  bit prev_we[N];
  bit stream [N];
  bit have   [N];

  task automatic chk(input bit ok, input string nm, input int i, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s inst%0d got %0d expected %0d (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  // One negedge sample of all instances: receiver model plus phase timing checks.
  task automatic mon_step();
    logic [8:0] e;
    bit cs, we;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!nRST) begin
        exp_q[i].delete();
        lo_len[i] = 0; hi_len[i] = 1000; we_len[i] = 0; npulse[i] = 0; ndone[i] = 0;
        fall_at[i] = 0; prev_cs[i] = 1'b1; prev_we[i] = 1'b0; stream[i] = 1'b0; have[i] = 1'b0;
        continue;
      end
      cs = j_cs[i];
      we = j_we[i];
      if (!tx_valid[i]) stream[i] = 1'b0;
      if (tx_valid[i] && tx_ready[i]) begin
        if (stream[i] && have[i])
          chk(cyc - last_acc[i] == per(i), "accept_period", i, cyc - last_acc[i], per(i));
        have[i] = 1'b1; last_acc[i] = cyc; stream[i] = 1'b1;
      end
      if (we) chk(!cs, "we_while_cs_high", i, int'(cs), 0);
      if (!cs) chk(busy[i], "busy_during_cycle", i, int'(busy[i]), 1);
      if (!cs) begin
        if (prev_cs[i]) begin
          chk(hi_len[i] >= tg(i) + 1, "cs_gap", i, hi_len[i], tg(i) + 1);
          lo_len[i] = 1; npulse[i] = 0; ndone[i] = 0;
        end else lo_len[i]++;
      end else begin
        if (!prev_cs[i]) begin
          chk(npulse[i] > 0 && lo_len[i] == npulse[i] * (ts(i) + tp(i) + th(i)),
              "cs_low_len", i, lo_len[i], npulse[i] * (ts(i) + tp(i) + th(i)));
          chk(ndone[i] == npulse[i], "done_count", i, ndone[i], npulse[i]);
          hi_len[i] = 1;
        end else hi_len[i]++;
      end
      if (we && !prev_we[i]) begin
        npulse[i]++;
        we_len[i] = 1;
        if (npulse[i] == 1) chk(lo_len[i] == ts(i) + 1, "setup_first", i, lo_len[i], ts(i) + 1);
        else chk(lo_len[i] == fall_at[i] + th(i) + ts(i), "setup_burst", i, lo_len[i],
                 fall_at[i] + th(i) + ts(i));
      end else if (we) we_len[i]++;
      if (!we && prev_we[i]) begin
        chk(we_len[i] == tp(i), "we_pulse", i, we_len[i], tp(i));
        fall_at[i] = lo_len[i];
        if (exp_q[i].size() == 0) chk(1'b0, "capture_unexpected", i, int'({j_rs[i], j_data[i]}), -1);
        else begin
          e = exp_q[i].pop_front();
          chk({j_rs[i], j_data[i]} == e, "capture", i, int'({j_rs[i], j_data[i]}), int'(e));
        end
      end
      if (tx_done[i]) begin
        ndone[i]++;
        chk(!cs && lo_len[i] == fall_at[i] + th(i) - 1, "done_pos", i, lo_len[i], fall_at[i] + th(i) - 1);
      end
      prev_cs[i] = cs;
      prev_we[i] = we;
    end
  endtask

  // Offer one byte; keep=1 leaves TxValid high so the next byte follows back-to-back.
  task automatic xfer(input int i, input bit cmd, input logic [7:0] d, input bit keep);
    int t = 0;
    tx_valid[i] = 1'b1; tx_iscmd[i] = cmd; tx_data[i] = d;
    do begin @(negedge CLK); t++; end while (!tx_ready[i] && t < 200);
    if (!tx_ready[i]) begin
      chk(1'b0, "accept_timeout", i, t, 200);
      tx_valid[i] = 1'b0;
      return;
    end
    exp_q[i].push_back({~cmd, d});
    @(posedge CLK); #1;
    if (!keep) begin
      tx_valid[i] = 1'b0; tx_iscmd[i] = 1'($urandom); tx_data[i] = 8'($urandom);
    end
  endtask

  task automatic traffic(input int i, input int n);
    bit keep;
    for (int k = 0; k < n; k++) begin
      keep = (k != n - 1) && ($urandom_range(0, 2) != 0);
      xfer(i, 1'($urandom), 8'($urandom), keep);
      if (!keep) begin
        // scramble the idle inputs while the bus cycle is in flight
        repeat ($urandom_range(0, 4)) begin
          @(posedge CLK); #1;
          tx_data[i] = 8'($urandom); tx_iscmd[i] = 1'($urandom);
        end
      end
    end
  endtask

  initial begin
    int t;
    nRST = 1'b0;
    for (int i = 0; i < N; i++) begin
      tx_valid[i] = 1'b0; tx_iscmd[i] = 1'b0; tx_data[i] = 8'h00;
    end
    fork
      forever begin @(negedge CLK); mon_step(); end
    join_none

    repeat (2) @(posedge CLK); #1;
    for (int i = 0; i < N; i++)
      chk({j_cs[i], j_rs[i], j_we[i], tx_done[i], tx_ready[i], busy[i], j_data[i]} == 14'b11_0_0_1_0_00000000,
          "reset_state", i, int'({j_cs[i], j_rs[i], j_we[i], tx_done[i], tx_ready[i], busy[i], j_data[i]}),
          int'(14'b11_0_0_1_0_00000000));
    nRST = 1'b1;
    repeat (2) @(posedge CLK); #1;

    fork
      begin
        xfer(0, 1'b0, 8'h60, 1'b0);
        repeat (8) @(posedge CLK); #1;
        xfer(0, 1'b1, 8'h2C, 1'b0);
        repeat (8) @(posedge CLK); #1;
        xfer(0, 1'b0, 8'h60, 1'b1);
        xfer(0, 1'b0, 8'h61, 1'b0);
        repeat (8) @(posedge CLK); #1;
        traffic(0, 40);
      end
      begin
        for (int b = 1; b <= 4; b++) xfer(1, 1'b0, 8'(b), b != 4);
        repeat (8) @(posedge CLK); #1;
        traffic(1, 50);
      end
      begin
        xfer(2, 1'b0, 8'hA5, 1'b0);
        repeat (20) @(posedge CLK); #1;
        traffic(2, 30);
      end
    join
    repeat (40) @(posedge CLK); #1;
    for (int i = 0; i < N; i++)
      chk(exp_q[i].size() == 0, "drained", i, exp_q[i].size(), 0);

    // Reset while We is high: everything returns to idle levels at once.
    xfer(0, 1'b0, 8'h5A, 1'b0);
    t = 0;
    while (!j_we[0] && t < 50) begin @(negedge CLK); t++; end
    chk(j_we[0], "reach_strobe", 0, int'(j_we[0]), 1);
    #2 nRST = 1'b0;
    #1;
    chk({j_cs[0], j_we[0], j_data[0]} == 10'b1_0_00000000, "async_reset", 0,
        int'({j_cs[0], j_we[0], j_data[0]}), int'(10'b1_0_00000000));
    @(negedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;
    #1;
    chk(tx_ready[0], "ready_after_reset", 0, int'(tx_ready[0]), 1);
    xfer(0, 1'b1, 8'hC3, 1'b0);
    xfer(0, 1'b0, 8'h3C, 1'b0);
    repeat (20) @(posedge CLK); #1;
    chk(exp_q[0].size() == 0, "drained_after_reset", 0, exp_q[0].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
